// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and the sync/blank bundle carried down the alignment pipe.
// Imported by the output driver and by the pixel generator for its visible-window offsets.
package vga_timing_pkg;

    localparam int H_SYNC_LEN    = 96;
    localparam int H_BACK_LEN    = 48;
    localparam int H_VISIBLE_LEN = 640;
    localparam int H_FRONT_LEN   = 16;

    localparam int V_SYNC_LEN    = 2;
    localparam int V_BACK_LEN    = 33;
    localparam int V_VISIBLE_LEN = 480;
    localparam int V_FRONT_LEN   = 10;

    localparam int H_TOTAL     = H_SYNC_LEN + H_BACK_LEN + H_VISIBLE_LEN + H_FRONT_LEN;
    localparam int V_TOTAL     = V_SYNC_LEN + V_BACK_LEN + V_VISIBLE_LEN + V_FRONT_LEN;
    localparam int H_VIS_START = H_SYNC_LEN + H_BACK_LEN;
    localparam int H_VIS_END   = H_VIS_START + H_VISIBLE_LEN - 1;
    localparam int V_VIS_START = V_SYNC_LEN + V_BACK_LEN;
    localparam int V_VIS_END   = V_VIS_START + V_VISIBLE_LEN - 1;

    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
    } vga_ctrl_t;

    // Inactive syncs, blanked: what the pins show before any real pixel reaches them.
    localparam vga_ctrl_t CTRL_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

endpackage

// File: rtl/vga_output_driver_counter.sv
// Wrapping up-counter: advances on enable, returns to 0 after reaching max.
// done flags the terminal count so a following counter can cascade off it.
module vga_output_driver_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    assign done = (count == max);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            count <= done ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_output_driver.sv
// VGA timing generator and pin driver: pixel-clock divider, h/v counters, sync/blank
// alignment pipe matching the pixel generator latency, and registered colour outputs.
module vga_output_driver
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int PIPE_DELAY = 1,
    parameter int H_SYNC     = H_SYNC_LEN,
    parameter int H_BACK     = H_BACK_LEN,
    parameter int H_VISIBLE  = H_VISIBLE_LEN,
    parameter int H_FRONT    = H_FRONT_LEN,
    parameter int V_SYNC     = V_SYNC_LEN,
    parameter int V_BACK     = V_BACK_LEN,
    parameter int V_VISIBLE  = V_VISIBLE_LEN,
    parameter int V_FRONT    = V_FRONT_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] rgb_in,
    output logic [9:0]  h_count,
    output logic [9:0]  v_count,
    output logic        pixel_tick,
    output logic        frame_start,
    output logic        vga_clk,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        blank_n,
    output logic        sync_n,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam logic [9:0] H_LAST     = 10'(H_SYNC + H_BACK + H_VISIBLE + H_FRONT - 1);
    localparam logic [9:0] V_LAST     = 10'(V_SYNC + V_BACK + V_VISIBLE + V_FRONT - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
    localparam logic [9:0] H_VIS_LO   = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_VIS_HI   = 10'(H_SYNC + H_BACK + H_VISIBLE - 1);
    localparam logic [9:0] V_VIS_LO   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_VIS_HI   = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic             h_done;
    logic             v_done;
    vga_ctrl_t        raw;
    vga_ctrl_t        stage_out;

    assign pixel_tick = (div == DIV_LAST);
    assign div_next   = pixel_tick ? '0 : div + 1'b1;

    // vga_clk is registered off the next divider value so it is glitch-free and in phase with div.
    always_ff @(posedge clk) begin
        if (reset) begin
            div     <= '0;
            vga_clk <= 1'b0;
        end else begin
            div     <= div_next;
            vga_clk <= (div_next >= DIV_HALF);
        end
    end

    vga_output_driver_counter #(.WIDTH(10)) u_h_counter (
        .clk    (clk),
        .reset  (reset),
        .enable (pixel_tick),
        .max    (H_LAST),
        .count  (h_count),
        .done   (h_done)
    );

    vga_output_driver_counter #(.WIDTH(10)) u_v_counter (
        .clk    (clk),
        .reset  (reset),
        .enable (pixel_tick & h_done),
        .max    (V_LAST),
        .count  (v_count),
        .done   (v_done)
    );

    assign frame_start = pixel_tick & h_done & v_done;

    assign raw.hs  = (h_count >= H_SYNC_END);
    assign raw.vs  = (v_count >= V_SYNC_END);
    assign raw.vis = (h_count >= H_VIS_LO) && (h_count <= H_VIS_HI)
                  && (v_count >= V_VIS_LO) && (v_count <= V_VIS_HI);

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign stage_out = raw;
        end else begin : g_delay
            vga_ctrl_t dly [PIPE_DELAY];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++) dly[i] <= CTRL_IDLE;
                end else if (pixel_tick) begin
                    dly[0] <= raw;
                    for (int i = 1; i < PIPE_DELAY; i++) dly[i] <= dly[i-1];
                end
            end

            assign stage_out = dly[PIPE_DELAY-1];
        end
    endgenerate

    // Colour is forced to black outside the visible window so the DAC never sees porch data.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_n   <= 1'b1;
            vsync_n   <= 1'b1;
            blank_n   <= 1'b0;
            {r, g, b} <= 24'h0;
        end else if (pixel_tick) begin
            hsync_n   <= stage_out.hs;
            vsync_n   <= stage_out.vs;
            blank_n   <= stage_out.vis;
            {r, g, b} <= stage_out.vis ? rgb_in : 24'h0;
        end
    end

    assign sync_n = 1'b0;

endmodule

// File: tb/tb_vga_output_driver.sv
// Scoreboard bench: three full-timing drivers (PIPE_DELAY 0/1/3, rgb = delayed h_count) and
// one shrunken-timing driver (constant colour) so whole frames fit in a short run.
module tb_vga_output_driver;

    localparam int CD = 2;
    localparam int PD_TAB [4] = '{0, 1, 3, 1};
    localparam logic [27:0] IDLE = {1'b1, 1'b1, 1'b0, 1'b0, 24'h0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   rst_at_edge = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rst_at_edge = rst;

    task automatic chk(input int inst, input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (dut %0d): got 0x%0h, expected 0x%0h", name, inst, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int PD    = PD_TAB[gi];
        localparam bit SMALL = (gi == 3);
        localparam int HS = SMALL ? 4 : 96;
        localparam int HB = SMALL ? 3 : 48;
        localparam int HV = SMALL ? 8 : 640;
        localparam int HF = SMALL ? 2 : 16;
        localparam int VS = 2;
        localparam int VB = SMALL ? 2 : 33;
        localparam int VV = SMALL ? 5 : 480;
        localparam int VF = SMALL ? 1 : 10;
        localparam int HT = HS + HB + HV + HF;
        localparam int VT = VS + VB + VV + VF;
        localparam logic [23:0] FIRST_RGB = SMALL ? 24'hFF8001 : 24'(HS + HB);
        localparam logic [23:0] LAST_RGB  = SMALL ? 24'hFF8001 : 24'(HS + HB + HV - 1);

        logic [23:0] rgb_in;
        logic [9:0]  h_count, v_count;
        logic        pixel_tick, frame_start, vga_clk, hsync_n, vsync_n, blank_n, sync_n;
        logic [7:0]  r, g, b;

        vga_output_driver #(
            .CLK_DIV(CD), .PIPE_DELAY(PD),
            .H_SYNC(HS), .H_BACK(HB), .H_VISIBLE(HV), .H_FRONT(HF),
            .V_SYNC(VS), .V_BACK(VB), .V_VISIBLE(VV), .V_FRONT(VF)
        ) u_dut (
            .clk(clk), .reset(rst), .rgb_in(rgb_in),
            .h_count(h_count), .v_count(v_count), .pixel_tick(pixel_tick),
            .frame_start(frame_start), .vga_clk(vga_clk),
            .hsync_n(hsync_n), .vsync_n(vsync_n), .blank_n(blank_n), .sync_n(sync_n),
            .r(r), .g(g), .b(b)
        );

        // Pixel-generator stand-in: returns h_count PD ticks later.
        logic [9:0] hd [8];
        always @(posedge clk) begin
            if (pixel_tick) begin
                hd[0] <= h_count;
                for (int k = 1; k < 8; k++) hd[k] <= hd[k-1];
            end
        end

        if (SMALL) begin : g_const
            assign rgb_in = 24'hFF8001;
        end else if (PD == 0) begin : g_direct
            assign rgb_in = {14'b0, h_count};
        end else begin : g_delayed
            assign rgb_in = {14'b0, hd[PD-1]};
        end

        logic [27:0] q [$];
        int          ph, mh, mv;
        bit          prev_tick;
        int          hs_run, bl_run, vs_run, line_cnt, fr_cnt, fs_seen;
        bit          line_armed, prev_blank, prev_hs;
        logic [23:0] prev_rgb;

        always @(negedge clk) begin
            logic [27:0] act_pins;
            logic [27:0] px;
            bit          tick, vis, fs_exp;
            act_pins = {hsync_n, vsync_n, blank_n, sync_n, r, g, b};
            if (rst_at_edge) begin
                chk(gi, "reset_pins", 64'(act_pins), 64'(IDLE));
                chk(gi, "reset_timing", 64'({pixel_tick, vga_clk, frame_start, h_count, v_count}), 64'd0);
                q.delete();
                for (int k = 0; k <= PD; k++) q.push_back(IDLE);
                ph = 0; mh = 0; mv = 0; prev_tick = 0;
                hs_run = 0; bl_run = 0; vs_run = 0; line_cnt = 0; fr_cnt = 0;
                line_armed = 0; prev_blank = 0; prev_hs = 1; prev_rgb = 24'h0;
            end else begin
                ph = (ph + 1) % CD;
                if (prev_tick) begin
                    if (q.size() > 0) void'(q.pop_front());
                    mh++;
                    if (mh == HT) begin
                        mh = 0;
                        mv++;
                        if (mv == VT) mv = 0;
                    end
                    // Pins just took a new pixel: run-length and edge checks.
                    if (!hsync_n) hs_run++;
                    else if (hs_run > 0) begin chk(gi, "hsync_width", 64'(hs_run), 64'(HS)); hs_run = 0; end
                    if (blank_n) bl_run++;
                    else if (bl_run > 0) begin chk(gi, "blank_width", 64'(bl_run), 64'(HV)); bl_run = 0; end
                    if (!vsync_n) vs_run++;
                    else if (vs_run > 0) begin chk(gi, "vsync_width", 64'(vs_run), 64'(VS * HT)); vs_run = 0; end
                    line_cnt++;
                    if (prev_hs && !hsync_n) begin
                        if (line_armed) chk(gi, "line_period", 64'(line_cnt), 64'(HT));
                        line_armed = 1;
                        line_cnt = 0;
                    end
                    if (blank_n && !prev_blank) chk(gi, "first_pixel", 64'({r, g, b}), 64'(FIRST_RGB));
                    if (!blank_n && prev_blank) chk(gi, "last_pixel", 64'(prev_rgb), 64'(LAST_RGB));
                    prev_blank = blank_n;
                    prev_hs = hsync_n;
                    prev_rgb = {r, g, b};
                end
                tick = (ph == CD - 1);
                fs_exp = tick && (mh == HT - 1) && (mv == VT - 1);
                chk(gi, "timing", 64'({pixel_tick, vga_clk, frame_start, h_count, v_count}),
                    64'({tick, (ph >= CD / 2), fs_exp, 10'(mh), 10'(mv)}));
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL scoreboard_underflow (dut %0d): got empty queue, expected an entry", gi);
                end else begin
                    chk(gi, "pins", 64'(act_pins), 64'(q[0]));
                end
                if (tick) begin
                    vis = (mh >= HS + HB) && (mh < HS + HB + HV) && (mv >= VS + VB) && (mv < VS + VB + VV);
                    px = {(mh >= HS), (mv >= VS), vis, 1'b0,
                          vis ? (SMALL ? 24'hFF8001 : 24'(mh)) : 24'h0};
                    q.push_back(px);
                    fr_cnt++;
                    if (frame_start) begin
                        chk(gi, "frame_period", 64'(fr_cnt), 64'(HT * VT));
                        fr_cnt = 0;
                        fs_seen++;
                    end
                end
                prev_tick = tick;
            end
        end
    end

    initial begin
        bit found;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6000) @(posedge clk);
        found = 0;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk);
            #1;
            if (g_dut[1].h_count == 10'd400) begin
                found = 1;
                break;
            end
        end
        chk(1, "reach_h400", 64'(found), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4000) @(posedge clk);
        @(negedge clk);
        chk(3, "frames_seen", 64'(g_dut[3].fs_seen >= 5), 64'd1);
        chk(1, "lines_seen", 64'(g_dut[1].line_armed), 64'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_output_driver.md
Name: vga_output_driver

Overview:
- Far (monitor-facing) end of the pixel path. Generates 640x480@60 VGA timing from the 50 MHz system clock and exports the raw h/v counters to the pixel generator.
- Takes the 24-bit rgb colour back from the pixel generator and aligns it with sync/blank by a configurable pipeline delay.
- Drives the DAC/connector pins: vga_clk, hsync_n, vsync_n, blank_n, sync_n, r/g/b.

Parameters:
- CLK_DIV, 2, system clocks per pixel; must be at least 2 (50 MHz -> 25 MHz pixel tick).
- PIPE_DELAY, 1, pixel ticks between h_count/v_count leaving this block and the matching rgb_in arriving; range 0-7.
- H_SYNC, 96 / H_BACK, 48 / H_VISIBLE, 640 / H_FRONT, 16: horizontal segment lengths in pixels; total 800.
- V_SYNC, 2 / V_BACK, 33 / V_VISIBLE, 480 / V_FRONT, 10: vertical segment lengths in lines; total 525.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- rgb_in  in  24  colour from the pixel generator, {r,g,b}
- h_count  out  10  horizontal counter, 0..799
- v_count  out  10  vertical counter, 0..524
- pixel_tick  out  1  one-clk strobe; counters advance on it
- frame_start  out  1  one-clk pulse on the tick where the counters go to (0,0)
- vga_clk  out  1  pixel clock to the DAC, 50% duty
- hsync_n  out  1  active-low horizontal sync
- vsync_n  out  1  active-low vertical sync
- blank_n  out  1  high only in the visible area
- sync_n  out  1  tied 0 (no sync-on-green)
- r, g, b  out  8 each  registered colour; zero whenever blanked

Behaviour:
- One clock (clk); reset is synchronous and active-high, named reset.
- Reset values:
  - divider = 0, pixel_tick = 0, vga_clk = 0
  - h_count = 0, v_count = 0
  - all delay-line stages = {hsync_n=1, vsync_n=1, blank_n=0}
  - outputs: hsync_n = 1, vsync_n = 1, blank_n = 0, r/g/b = 0, frame_start = 0
- Reset asserted mid-frame: the same values apply on the next edge, and the frame restarts from (0,0).
- Divider:
  - counts 0..CLK_DIV-1; pixel_tick = 1 for one clk when the divider = CLK_DIV-1.
  - vga_clk is high for the second half of each divider period.
- Counters advance only on pixel_tick:
  - h_count wraps 799 -> 0.
  - v_count increments only on the tick where h_count wraps; it wraps 524 -> 0.
  - frame_start = 1 on the tick where both counters wrap.
- Segment order is sync, back porch, visible, front porch, from count 0:
  - hsync active: h < 96. Visible columns: 144 <= h <= 783.
  - vsync active: v < 2. Visible lines: 35 <= v <= 514.
  - Raw timing values: hs = !(h<96); vs = !(v<2); vis = both in the visible window.
- Alignment:
  - {hs, vs, vis} enter a PIPE_DELAY-deep shift register that shifts only on pixel_tick.
  - The output register loads on pixel_tick from the last stage (from the raw values when PIPE_DELAY = 0).
  - Output register contents: hsync_n, vsync_n, blank_n; {r,g,b} = rgb_in when the delayed vis = 1, else 0.
- Latency: counters = (h,v) at tick n -> pins show that pixel's sync, blank and colour from tick n+PIPE_DELAY+1 until the next tick.
- Outputs change only on pixel_tick clocks. Between ticks the pins hold; rgb_in is sampled only on pixel_tick.
- Widths: counters are 10-bit unsigned, and every compare is against constants that fit in 10 bits.

Decomposition:
- Shared package vga_timing_pkg:
  - segment-length constants
  - derived H_TOTAL=800, V_TOTAL=525, H_VIS_START=144, H_VIS_END=783, V_VIS_START=35, V_VIS_END=514
  - typedef struct packed {logic hs, vs, vis;} vga_ctrl_t for delay-line stages
- The pixel generator imports the same package for its visible-window offsets.
- Sub-module: reuse the existing counter module (parameterised width, enable/max/done) twice:
  - h counter, enable = pixel_tick
  - v counter, enable = h done & pixel_tick
- The divider and the delay line stay inline.

Test Plan:
- Reset held 5 clks, then released -> during reset hsync_n=1, vsync_n=1, blank_n=0, rgb=0; first pixel_tick on the 2nd clk after release; h_count=1 after that tick.
- Free-run one line, PIPE_DELAY=1 -> hsync_n low for exactly 96 ticks (192 clks); line period 800 ticks; blank_n high for 640 consecutive ticks, first asserted 2 ticks after h_count=144.
- Free-run one frame -> vsync_n low for 2 lines (1600 ticks); frame_start pulses every 420000 ticks; v_count wraps 524 -> 0 on the tick where h_count wraps 799 -> 0.
- rgb_in = 24'hFF8001 constant -> r=FF, g=80, b=01 only while blank_n=1; r/g/b = 0 during porches and sync.
- Drive rgb_in = {14'b0, h_count} delayed by PIPE_DELAY ticks, for PIPE_DELAY = 0, 1 and 3 -> the first visible output pixel is always 24'd144 and the last is 24'd783.
- Assert reset at h=400, v=200 -> next clk: outputs at reset values, counters at 0; normal timing resumes and frame_start is next seen a full 420000 ticks later.
